// File: rtl/vga_timing_out_if.sv
// Signal bundle between the VGA timing generator and its renderer/monitor.
// master = timing generator side, slave = renderer / display side.
interface vga_timing_out_if;
  logic [10:0] x;
  logic [10:0] y;
  logic [7:0]  rgb_in;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        frame_start;

  modport master (
    output x, y, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    input  rgb_in
  );

  modport slave (
    input  x, y, vga_r, vga_g, vga_b, hsync, vsync, frame_start,
    output rgb_in
  );
endinterface

// File: rtl/vga_timing_out.sv
// 640x480 @ 60 Hz VGA timing generator with 2-clk aligned sync/colour outputs.
// Optional macro VGA_PIXDIV_EN: divide a 100 MHz clk down to a 25 MHz pixel tick.
module vga_timing_out (
  input  logic              clk,
  input  logic              reset,
  vga_timing_out_if.master  vga
);

  localparam logic [10:0] H_ACTIVE_END = 11'd640;
  localparam logic [10:0] H_SYNC_START = 11'd656;
  localparam logic [10:0] H_BACK_START = 11'd752;
  localparam logic [10:0] H_LAST       = 11'd799;
  localparam logic [10:0] V_ACTIVE_END = 11'd480;
  localparam logic [10:0] V_SYNC_START = 11'd490;
  localparam logic [10:0] V_BACK_START = 11'd492;
  localparam logic [10:0] V_LAST       = 11'd524;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_started;
  logic        r_frameStart;
  logic        w_tick;

  phase_t      w_hPhase;
  phase_t      w_vPhase;
  logic        w_hsRaw;
  logic        w_vsRaw;
  logic        w_activeRaw;

  logic        r_hs1;
  logic        r_vs1;
  logic        r_act1;
  logic        r_hs2;
  logic        r_vs2;
  logic [7:0]  r_colour;

`ifdef VGA_PIXDIV_EN
  // The divider is frozen on the release clk so that (0,0) also lasts a full 4 clk.
  logic [1:0] r_div;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 2'd0;
    end else if (r_started) begin
      r_div <= r_div + 2'd1;
    end
  end

  assign w_tick = r_started && (r_div == 2'd3);
`else
  assign w_tick = r_started;
`endif

  // The first clk after reset holds (0,0) and announces the frame before counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= 11'd0;
      r_y          <= 11'd0;
      r_started    <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= 1'b0;
      if (!r_started) begin
        r_started    <= 1'b1;
        r_frameStart <= 1'b1;
      end else if (w_tick) begin
        if (r_x == H_LAST) begin
          r_x <= 11'd0;
          if (r_y == V_LAST) begin
            r_y          <= 11'd0;
            r_frameStart <= 1'b1;
          end else begin
            r_y <= r_y + 11'd1;
          end
        end else begin
          r_x <= r_x + 11'd1;
        end
      end
    end
  end

  always_comb begin
    w_hPhase = PH_BACK;
    if (r_x < H_ACTIVE_END)      w_hPhase = PH_ACTIVE;
    else if (r_x < H_SYNC_START) w_hPhase = PH_FRONT;
    else if (r_x < H_BACK_START) w_hPhase = PH_SYNC;

    w_vPhase = PH_BACK;
    if (r_y < V_ACTIVE_END)      w_vPhase = PH_ACTIVE;
    else if (r_y < V_SYNC_START) w_vPhase = PH_FRONT;
    else if (r_y < V_BACK_START) w_vPhase = PH_SYNC;
  end

  assign w_hsRaw     = (w_hPhase != PH_SYNC);
  assign w_vsRaw     = (w_vPhase != PH_SYNC);
  assign w_activeRaw = (w_hPhase == PH_ACTIVE) && (w_vPhase == PH_ACTIVE);

  // Stage 1 meets rgb_in as it arrives; the colour register is stage 2 of active.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs1    <= 1'b1;
      r_vs1    <= 1'b1;
      r_act1   <= 1'b0;
      r_hs2    <= 1'b1;
      r_vs2    <= 1'b1;
      r_colour <= 8'd0;
    end else begin
      r_hs1    <= w_hsRaw;
      r_vs1    <= w_vsRaw;
      r_act1   <= w_activeRaw;
      r_hs2    <= r_hs1;
      r_vs2    <= r_vs1;
      r_colour <= r_act1 ? vga.rgb_in : 8'd0;
    end
  end

  assign vga.x           = r_x;
  assign vga.y           = r_y;
  assign vga.frame_start = r_frameStart;
  assign vga.hsync       = r_hs2;
  assign vga.vsync       = r_vs2;
  assign vga.vga_r       = r_colour[2:0];
  assign vga.vga_g       = r_colour[5:3];
  assign vga.vga_b       = r_colour[7:6];

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: pixel-index reference model on every clk, a vector table
// of line landmarks, and hand sequences for reset-in-sync and hsync width.
`timescale 1ns/1ps
module tb_vga_timing_out;

`ifdef VGA_PIXDIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   rgbRandom = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vga_timing_out_if vga();

  vga_timing_out dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vga)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Every clk after an edge with reset low is one pixel tick per DIV clk, first clk held.
  function automatic void pixelPos(input int k, output int px, output int py);
    int p;
    p  = (k == 0) ? 0 : (k - 1) / DIV;
    px = p % 800;
    py = (p / 800) % 525;
  endfunction

  int  kEdges = 0;
  int  prevX = 0, prevY = 0, prev2X = 0, prev2Y = 0;
  bit  prevReset = 1'b1;

  always begin
    int         px, py;
    bit         rNow, expHs, expVs, expFs, act;
    logic [7:0] expCol;
    @(posedge clk);
    #1;
    rNow = reset;
    if (rNow) kEdges = 0;
    else      kEdges++;
    pixelPos(kEdges, px, py);
    expFs = !rNow && px == 0 && py == 0 && (prevReset || prevX != 0 || prevY != 0);
    if (rNow || prevReset) begin
      expHs  = 1'b1;
      expVs  = 1'b1;
      expCol = 8'd0;
    end else begin
      expHs  = !(prev2X >= 656 && prev2X <= 751);
      expVs  = !(prev2Y >= 490 && prev2Y <= 491);
      act    = prev2X < 640 && prev2Y < 480;
      expCol = act ? vga.rgb_in : 8'd0;
    end
    checkOutput("model_x", 32'(vga.x), 32'(px));
    checkOutput("model_y", 32'(vga.y), 32'(py));
    checkOutput("model_hsync", 32'(vga.hsync), 32'(expHs));
    checkOutput("model_vsync", 32'(vga.vsync), 32'(expVs));
    checkOutput("model_colour", 32'({vga.vga_b, vga.vga_g, vga.vga_r}), 32'(expCol));
    checkOutput("model_frame_start", 32'(vga.frame_start), 32'(expFs));
    prev2X    = prevX;
    prev2Y    = prevY;
    prevX     = px;
    prevY     = py;
    prevReset = rNow;
  end

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rgbRandom) vga.rgb_in = 8'($urandom);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3);
    reset = 1'b0;
  endtask

  typedef struct {
    int         pix;
    int         ex;
    int         ey;
    bit         ehs;
    logic [7:0] ecol;
    bit         efs;
  } vec_t;

  vec_t vecs[10];
  int   lowCount, fsCount;

  initial begin
    vga.rgb_in = 8'hFF;

    vecs[0] = '{0,    0,   0, 1'b1, 8'hFF, 1'b1};
    vecs[1] = '{639,  639, 0, 1'b1, 8'hFF, 1'b0};
    vecs[2] = '{640,  640, 0, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{655,  655, 0, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{656,  656, 0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{751,  751, 0, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{752,  752, 0, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{799,  799, 0, 1'b1, 8'h00, 1'b0};
    vecs[8] = '{800,  0,   1, 1'b1, 8'hFF, 1'b0};
    vecs[9] = '{1456, 656, 1, 1'b0, 8'h00, 1'b0};

    applyStimulus(4);
    checkOutput("reset_x", 32'(vga.x), 32'd0);
    checkOutput("reset_hsync", 32'(vga.hsync), 32'd1);
    checkOutput("reset_frame_start", 32'(vga.frame_start), 32'd0);

    // Colour held at all-ones so blanking shows up as zero.
    for (int i = 0; i < 10; i++) begin
      resetDut();
      applyStimulus(vecs[i].pix * DIV + 1);
      checkOutput($sformatf("vec%0d_x", i), 32'(vga.x), 32'(vecs[i].ex));
      checkOutput($sformatf("vec%0d_y", i), 32'(vga.y), 32'(vecs[i].ey));
      checkOutput($sformatf("vec%0d_frame_start", i), 32'(vga.frame_start), 32'(vecs[i].efs));
      applyStimulus(2);
      checkOutput($sformatf("vec%0d_hsync", i), 32'(vga.hsync), 32'(vecs[i].ehs));
      checkOutput($sformatf("vec%0d_colour", i), 32'({vga.vga_b, vga.vga_g, vga.vga_r}), 32'(vecs[i].ecol));
    end

    // Reset landing in the middle of hsync must clear sync immediately.
    rgbRandom = 1'b1;
    resetDut();
    applyStimulus(700 * DIV + 3);
    checkOutput("midsync_x", 32'(vga.x), 32'(((700 * DIV + 2) / DIV) % 800));
    checkOutput("midsync_hsync_low", 32'(vga.hsync), 32'd0);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midsync_rst_x", 32'(vga.x), 32'd0);
    checkOutput("midsync_rst_y", 32'(vga.y), 32'd0);
    checkOutput("midsync_rst_hsync", 32'(vga.hsync), 32'd1);
    checkOutput("midsync_rst_vsync", 32'(vga.vsync), 32'd1);
    checkOutput("midsync_rst_colour", 32'({vga.vga_b, vga.vga_g, vga.vga_r}), 32'd0);
    checkOutput("midsync_rst_frame_start", 32'(vga.frame_start), 32'd0);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("release_frame_start", 32'(vga.frame_start), 32'd1);
    checkOutput("release_x_held", 32'(vga.x), 32'd0);
    applyStimulus(1);
    checkOutput("release_frame_start_width", 32'(vga.frame_start), 32'd0);
    checkOutput("release_x_next", 32'(vga.x), 32'((DIV == 1) ? 1 : 0));

    // One full line: hsync width and a single frame_start pulse.
    resetDut();
    lowCount = 0;
    fsCount  = 0;
    repeat (800 * DIV + 2) begin
      applyStimulus(1);
      if (!vga.hsync) lowCount++;
      if (vga.frame_start) fsCount++;
    end
    checkOutput("line_hsync_low_clks", 32'(lowCount), 32'(96 * DIV));
    checkOutput("line_frame_start_count", 32'(fsCount), 32'd1);
    applyStimulus(900 * DIV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
